// File: rtl/bus_cycle_sequencer_pkg.sv
// Shared types and constants for the 65C02-style bus cycle sequencer.
package bus_seq_pkg;

  typedef enum logic {IDLE, ACTIVE} state_t;

  typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_t;

  localparam logic [1:0] Q_LAST = 2'b11;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way combinational arbiter: bit 0 = CPU, bit 1 = DMA.
module rr_arbiter2
  import bus_seq_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       last_owner,
  output logic [1:0] grant
);

  logic [1:0] eligible;

  always_comb begin
    eligible = req & ~mask;
    grant    = eligible;
    if (eligible == 2'b11) begin
      // Round-robin hands the bus to whoever did not own it last; otherwise DMA wins.
      if ((RR_EN != 0) && (last_owner == OWN_DMA)) grant = 2'b01;
      else                                         grant = 2'b10;
    end
  end

endmodule

// File: rtl/bus_cycle_sequencer.sv
// Single-beat CPU/DMA bus sequencer; one bus cycle per q revolution, stretched by bus_rdy.
module bus_cycle_sequencer
  import bus_seq_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 15,
  parameter int RR_EN    = 1
) (
  input  logic              fclk,
  input  logic              reset,
  input  logic [1:0]        q,
  input  logic              p,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic              dma_err,
  output logic [DATA_W-1:0] rdata,
  output logic              owner,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rwb,
  output logic [DATA_W-1:0] bus_dout,
  output logic              bus_doe,
  output logic              bus_vda,
  input  logic [DATA_W-1:0] bus_din,
  input  logic              bus_rdy
);

  localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cpu_ack_q, cpu_ack_d, cpu_err_q, cpu_err_d;
  logic              dma_ack_q, dma_ack_d, dma_err_q, dma_err_d;

  logic       at_last;
  logic       timed_out;
  logic       complete;
  logic       arb_en;
  logic [1:0] mask;
  logic [1:0] grant;

  assign at_last   = (q == Q_LAST);
  assign timed_out = (wait_cnt_q == WCW'(MAX_WAIT));
  assign complete  = (state_q == ACTIVE) && at_last && (bus_rdy || timed_out);
  assign arb_en    = at_last && ((state_q == IDLE) || complete);
  assign mask      = complete ? ((owner_q == OWN_DMA) ? 2'b10 : 2'b01) : 2'b00;

  rr_arbiter2 #(.RR_EN(RR_EN)) u_arb (
    .req       ({dma_req, cpu_req}),
    .mask      (mask),
    .last_owner(owner_q),
    .grant     (grant)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cpu_ack_d  = 1'b0;
    cpu_err_d  = 1'b0;
    dma_ack_d  = 1'b0;
    dma_err_d  = 1'b0;

    if (complete) begin
      if (bus_rdy && !we_q) rdata_d = bus_din;
      if (owner_q == OWN_DMA) begin
        dma_ack_d = 1'b1;
        dma_err_d = ~bus_rdy;
      end else begin
        cpu_ack_d = 1'b1;
        cpu_err_d = ~bus_rdy;
      end
    end else if ((state_q == ACTIVE) && at_last) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    if (arb_en) begin
      state_d    = ACTIVE;
      wait_cnt_d = '0;
      if (grant[1]) begin
        owner_d = OWN_DMA;
        addr_d  = dma_addr;
        we_d    = dma_we;
        wdata_d = dma_wdata;
      end else if (grant[0]) begin
        owner_d = OWN_CPU;
        addr_d  = cpu_addr;
        we_d    = cpu_we;
        wdata_d = cpu_wdata;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge fclk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_CPU;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cpu_ack_q  <= 1'b0;
      cpu_err_q  <= 1'b0;
      dma_ack_q  <= 1'b0;
      dma_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      cpu_ack_q  <= cpu_ack_d;
      cpu_err_q  <= cpu_err_d;
      dma_ack_q  <= dma_ack_d;
      dma_err_q  <= dma_err_d;
    end
  end

  assign bus_vda  = (state_q == ACTIVE);
  assign bus_rwb  = ~(bus_vda & we_q);
  assign bus_addr = addr_q;
  assign bus_dout = wdata_q;
  assign bus_doe  = bus_vda & ~bus_rwb & p;
  assign cpu_ack  = cpu_ack_q;
  assign cpu_err  = cpu_err_q;
  assign dma_ack  = dma_ack_q;
  assign dma_err  = dma_err_q;
  assign rdata    = rdata_q;
  assign owner    = owner_q;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Directed bench for bus_cycle_sequencer: round-robin instance plus a fixed-priority instance.
module tb_bus_cycle_sequencer;

  logic        fclk = 1'b0;
  logic        reset;
  logic [1:0]  q = 2'd1;
  logic        p;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata, bus_din;
  logic        bus_rdy;

  logic        cpu_ack, cpu_err, dma_ack, dma_err, owner;
  logic [7:0]  rdata, bus_dout;
  logic [15:0] bus_addr;
  logic        bus_rwb, bus_doe, bus_vda;

  logic        fp_cpu_ack, fp_cpu_err, fp_dma_ack, fp_dma_err, fp_owner;
  logic [7:0]  fp_rdata, fp_bus_dout;
  logic [15:0] fp_bus_addr;
  logic        fp_bus_rwb, fp_bus_doe, fp_bus_vda;

  int checks = 0;
  int errors = 0;

  always #5 fclk = ~fclk;
  always @(posedge fclk) q <= q + 2'd1;
  assign p = q[1];

  bus_cycle_sequencer #(.ADDR_W(16), .DATA_W(8), .MAX_WAIT(15), .RR_EN(1)) dut (
    .fclk(fclk), .reset(reset), .q(q), .p(p),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_err(dma_err),
    .rdata(rdata), .owner(owner),
    .bus_addr(bus_addr), .bus_rwb(bus_rwb), .bus_dout(bus_dout), .bus_doe(bus_doe),
    .bus_vda(bus_vda), .bus_din(bus_din), .bus_rdy(bus_rdy)
  );

  bus_cycle_sequencer #(.ADDR_W(16), .DATA_W(8), .MAX_WAIT(15), .RR_EN(0)) dut_fp (
    .fclk(fclk), .reset(reset), .q(q), .p(p),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(fp_cpu_ack), .cpu_err(fp_cpu_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(fp_dma_ack), .dma_err(fp_dma_err),
    .rdata(fp_rdata), .owner(fp_owner),
    .bus_addr(fp_bus_addr), .bus_rwb(fp_bus_rwb), .bus_dout(fp_bus_dout), .bus_doe(fp_bus_doe),
    .bus_vda(fp_bus_vda), .bus_din(bus_din), .bus_rdy(bus_rdy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic wait_q(input logic [1:0] k);
    for (int i = 0; i < 8; i++) begin
      @(negedge fclk);
      if (q == k) return;
    end
  endtask

  // Called on the q=0 negedge of an active revolution; leaves the bench on its q=3 negedge.
  task automatic bus_rev(input logic [15:0] a, input logic rd, input logic [7:0] wd,
                         input logic [7:0] din, input logic rdy3, input logic exp_own);
    for (int ph = 0; ph < 4; ph++) begin
      if (ph > 0) @(negedge fclk);
      bus_rdy = (ph == 3) ? rdy3 : ~rdy3;
      bus_din = (ph == 3) ? din : 8'h00;
      check_eq("rev_vda",   32'(bus_vda), 32'(1'b1));
      check_eq("rev_addr",  32'(bus_addr), 32'(a));
      check_eq("rev_rwb",   32'(bus_rwb), 32'(rd));
      check_eq("rev_doe",   32'(bus_doe), 32'(!rd && (ph >= 2)));
      check_eq("rev_owner", 32'(owner), 32'(exp_own));
      if (!rd) check_eq("rev_dout", 32'(bus_dout), 32'(wd));
      if (ph > 0) check_eq("rev_no_ack", 32'({cpu_ack, dma_ack}), 32'(2'b00));
    end
  endtask

  task automatic ack_chk(input string tag, input logic ec, input logic ed, input logic ee,
                         input logic [7:0] er);
    check_eq({tag, "_cpu_ack"}, 32'(cpu_ack), 32'(ec));
    check_eq({tag, "_dma_ack"}, 32'(dma_ack), 32'(ed));
    check_eq({tag, "_cpu_err"}, 32'(cpu_err), 32'(ec & ee));
    check_eq({tag, "_dma_err"}, 32'(dma_err), 32'(ed & ee));
    check_eq({tag, "_rdata"},   32'(rdata), 32'(er));
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    bus_rdy = 1'b1; bus_din = '0;
    repeat (3) @(negedge fclk);

    check_eq("rst_vda",   32'(bus_vda), 32'(1'b0));
    check_eq("rst_rwb",   32'(bus_rwb), 32'(1'b1));
    check_eq("rst_addr",  32'(bus_addr), 32'h0);
    check_eq("rst_dout",  32'(bus_dout), 32'h0);
    check_eq("rst_doe",   32'(bus_doe), 32'(1'b0));
    check_eq("rst_owner", 32'(owner), 32'(1'b0));
    check_eq("rst_rdata", 32'(rdata), 32'h0);
    check_eq("rst_acks",  32'({cpu_ack, cpu_err, dma_ack, dma_err}), 32'h0);
    reset = 1'b0;

    // CPU read
    wait_q(2'd0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234; cpu_wdata = 8'hEE;
    wait_q(2'd3);
    check_eq("idle_vda", 32'(bus_vda), 32'(1'b0));
    check_eq("idle_rwb", 32'(bus_rwb), 32'(1'b1));
    @(negedge fclk);
    bus_rev(16'h1234, 1'b1, 8'h00, 8'hA5, 1'b1, 1'b0);
    @(negedge fclk);
    ack_chk("rd", 1'b1, 1'b0, 1'b0, 8'hA5);
    cpu_req = 1'b0;

    // Two wait states, then capture
    wait_q(2'd0);
    cpu_req = 1'b1; cpu_addr = 16'h4321;
    wait_q(2'd3);
    @(negedge fclk); bus_rev(16'h4321, 1'b1, 8'h00, 8'h11, 1'b0, 1'b0);
    @(negedge fclk); bus_rev(16'h4321, 1'b1, 8'h00, 8'h22, 1'b0, 1'b0);
    @(negedge fclk); bus_rev(16'h4321, 1'b1, 8'h00, 8'h5A, 1'b1, 1'b0);
    @(negedge fclk);
    ack_chk("wait", 1'b1, 1'b0, 1'b0, 8'h5A);
    cpu_req = 1'b0;

    // Timeout after 16 revolutions
    wait_q(2'd0);
    cpu_req = 1'b1; cpu_addr = 16'h0F0F;
    wait_q(2'd3);
    for (int i = 0; i < 16; i++) begin
      @(negedge fclk);
      bus_rev(16'h0F0F, 1'b1, 8'h00, 8'hFF, 1'b0, 1'b0);
    end
    @(negedge fclk);
    ack_chk("tmo", 1'b1, 1'b0, 1'b1, 8'h5A);
    check_eq("tmo_idle", 32'(bus_vda), 32'(1'b0));
    cpu_req = 1'b0;
    bus_rdy = 1'b1;

    // DMA write
    wait_q(2'd0);
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h8000; dma_wdata = 8'h3C;
    wait_q(2'd3);
    @(negedge fclk);
    bus_rev(16'h8000, 1'b0, 8'h3C, 8'h99, 1'b1, 1'b1);
    @(negedge fclk);
    ack_chk("wr", 1'b0, 1'b1, 1'b0, 8'h5A);
    dma_req = 1'b0;

    // Contention: last owner is DMA, so RR starts with CPU; fixed priority starts with DMA
    wait_q(2'd0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1111;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h2222; dma_wdata = 8'h77;
    wait_q(2'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge fclk);
      if (i > 0) begin
        if ((i - 1) % 2 == 0) ack_chk("rr", 1'b1, 1'b0, 1'b0, 8'(8'h40 + i - 1));
        else                  ack_chk("rr", 1'b0, 1'b1, 1'b0, 8'(8'h40 + i - 2));
        check_eq("fp_cpu_ack", 32'(fp_cpu_ack), 32'((i - 1) % 2 == 1));
        check_eq("fp_dma_ack", 32'(fp_dma_ack), 32'((i - 1) % 2 == 0));
      end
      if (i == 4) dma_req = 1'b0;
      if (i % 2 == 0) bus_rev(16'h1111, 1'b1, 8'h00, 8'(8'h40 + i), 1'b1, 1'b0);
      else            bus_rev(16'h2222, 1'b0, 8'h77, 8'(8'h40 + i), 1'b1, 1'b1);
    end
    @(negedge fclk);
    ack_chk("rr_last", 1'b1, 1'b0, 1'b0, 8'h44);
    check_eq("fp_last_dma_ack", 32'(fp_dma_ack), 32'(1'b1));
    check_eq("rr_idle", 32'(bus_vda), 32'(1'b0));
    cpu_req = 1'b0;

    // Reset during a stretched read
    reset = 1'b1;
    repeat (2) @(negedge fclk);
    reset = 1'b0;
    wait_q(2'd0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h5555;
    wait_q(2'd3);
    @(negedge fclk);
    bus_rev(16'h5555, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge fclk);
    check_eq("mid_vda", 32'(bus_vda), 32'(1'b1));
    @(negedge fclk);
    reset = 1'b1;
    @(negedge fclk);
    check_eq("rst_mid_vda", 32'(bus_vda), 32'(1'b0));
    check_eq("rst_mid_ack", 32'({cpu_ack, dma_ack}), 32'(2'b00));
    reset = 1'b0;
    @(negedge fclk);
    check_eq("post_rst_idle", 32'(bus_vda), 32'(1'b0));
    @(negedge fclk);
    bus_rev(16'h5555, 1'b1, 8'h00, 8'hC3, 1'b1, 1'b0);
    @(negedge fclk);
    ack_chk("post_rst", 1'b1, 1'b0, 1'b0, 8'hC3);
    cpu_req = 1'b0;

    repeat (4) @(negedge fclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
